// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types and arithmetic helpers for the Sobel stream core
package sobel_pkg;

  typedef enum logic {MODE_MAG = 1'b0, MODE_THRESH = 1'b1} mode_e;

  // Gradient headroom: |G| <= 4*(2^DW-1) needs two extra magnitude bits plus sign.
  localparam int GRAD_EXTRA = 3;

  function automatic int unsigned gray_f(input int unsigned r, input int unsigned g,
                                         input int unsigned b);
    return (r + 2 * g + b) >> 2;
  endfunction

  function automatic int unsigned sat_f(input int unsigned m, input int unsigned max_v);
    return (m > max_v) ? max_v : m;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - two-row gray line store, read-before-write at one address
module sobel_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] row1,
  output logic [DATA_WIDTH-1:0] row2
);

  logic [DATA_WIDTH-1:0] mem1 [DEPTH];
  logic [DATA_WIDTH-1:0] mem2 [DEPTH];

  assign row1 = mem1[addr];
  assign row2 = mem2[addr];

  // mem1 holds the previous row, mem2 the one before; a write ages both.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem1[addr] <= wr_data;
      mem2[addr] <= mem1[addr];
    end
  end

endmodule

// File: rtl/sobel_stream_core.sv
// rtl/sobel_stream_core.sv - streaming 3x3 Sobel edge engine with valid/ready handshake
module sobel_stream_core
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 1024,
  parameter int DIM_W      = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIM_W-1:0]        cfg_width,
  input  logic [DIM_W-1:0]        cfg_height,
  input  logic                    cfg_mode,
  input  logic [DATA_WIDTH-1:0]   cfg_thresh,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [3*DATA_WIDTH-1:0] s_data,
  input  logic                    s_sof,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [3*DATA_WIDTH-1:0] m_data,
  output logic                    m_sof,
  output logic                    m_eol,
  output logic                    frame_done
);

  localparam int AW = $clog2(MAX_WIDTH);
  localparam int GW = DATA_WIDTH + GRAD_EXTRA;
  localparam int MW = GW + 1;
  localparam int unsigned PIX_MAX = (32'd1 << DATA_WIDTH) - 32'd1;
  localparam logic [DIM_W:0]   MAXW_L = (DIM_W + 1)'(MAX_WIDTH);
  localparam logic [DIM_W-1:0] TWO    = DIM_W'(2);

  logic adv, accept;
  assign adv     = !m_valid || m_ready;
  assign s_ready = adv;
  assign accept  = s_valid && adv;

  logic                  active_q, ok_q, active_c, ok_c;
  logic [DIM_W-1:0]      row_q, col_q, w_q, h_q, row_c, col_c, w_c, h_c;
  mode_e                 mode_q, mode_c;
  logic [DATA_WIDTH-1:0] th_q, th_c;

  // An SOF beat overrides the stored position and configuration for itself.
  always_comb begin
    active_c = active_q;
    ok_c     = ok_q;
    row_c    = row_q;
    col_c    = col_q;
    w_c      = w_q;
    h_c      = h_q;
    mode_c   = mode_q;
    th_c     = th_q;
    if (s_sof) begin
      active_c = 1'b1;
      row_c    = '0;
      col_c    = '0;
      w_c      = cfg_width;
      h_c      = cfg_height;
      mode_c   = mode_e'(cfg_mode);
      th_c     = cfg_thresh;
      ok_c     = (cfg_width >= TWO + 1'b1) && (cfg_height >= TWO + 1'b1) &&
                 ({1'b0, cfg_width} <= MAXW_L);
    end
  end

  logic beat_live, emit, last_col, last_row;
  assign beat_live = accept && active_c && ok_c;
  assign last_col  = (col_c == w_c - 1'b1);
  assign last_row  = (row_c == h_c - 1'b1);
  assign emit      = beat_live && (row_c >= TWO) && (col_c >= TWO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      ok_q     <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      w_q      <= '0;
      h_q      <= '0;
      mode_q   <= MODE_MAG;
      th_q     <= '0;
    end else if (accept) begin
      ok_q     <= ok_c;
      w_q      <= w_c;
      h_q      <= h_c;
      mode_q   <= mode_c;
      th_q     <= th_c;
      active_q <= active_c && ok_c && !(last_col && last_row);
      col_q    <= last_col ? '0 : col_c + 1'b1;
      row_q    <= last_col ? row_c + 1'b1 : row_c;
    end
  end

  logic [DATA_WIDTH-1:0] gray, lb_row1, lb_row2;
  assign gray = DATA_WIDTH'(gray_f(32'(s_data[3*DATA_WIDTH-1:2*DATA_WIDTH]),
                                   32'(s_data[2*DATA_WIDTH-1:DATA_WIDTH]),
                                   32'(s_data[DATA_WIDTH-1:0])));

  sobel_line_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (MAX_WIDTH),
    .AW        (AW)
  ) u_line_buffer (
    .clk    (clk),
    .wr_en  (beat_live),
    .addr   (col_c[AW-1:0]),
    .wr_data(gray),
    .row1   (lb_row1),
    .row2   (lb_row2)
  );

  // Window indexed [row][col]: row 0 oldest line, col 2 newest column.
  logic [DATA_WIDTH-1:0] win [3][3];
  logic                  s0_valid, s0_sof, s0_eol, s0_last;
  mode_e                 s0_mode;
  logic [DATA_WIDTH-1:0] s0_th;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win      <= '{default: '0};
      s0_valid <= 1'b0;
      s0_sof   <= 1'b0;
      s0_eol   <= 1'b0;
      s0_last  <= 1'b0;
      s0_mode  <= MODE_MAG;
      s0_th    <= '0;
    end else if (adv) begin
      if (beat_live) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb_row2;
        win[1][2] <= lb_row1;
        win[2][2] <= gray;
      end
      s0_valid <= emit;
      s0_sof   <= emit && (row_c == TWO) && (col_c == TWO);
      s0_eol   <= emit && last_col;
      s0_last  <= emit && last_col && last_row;
      s0_mode  <= mode_c;
      s0_th    <= th_c;
    end
  end

  logic signed [GW-1:0] p [3][3];
  logic signed [GW-1:0] gx_c, gy_c;
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = $signed({{GRAD_EXTRA{1'b0}}, win[r][c]});
    gx_c = (p[0][2] + p[1][2] + p[1][2] + p[2][2]) - (p[0][0] + p[1][0] + p[1][0] + p[2][0]);
    gy_c = (p[2][0] + p[2][1] + p[2][1] + p[2][2]) - (p[0][0] + p[0][1] + p[0][1] + p[0][2]);
  end

  logic                  s1_valid, s1_sof, s1_eol, s1_last;
  logic signed [GW-1:0]  s1_gx, s1_gy;
  mode_e                 s1_mode;
  logic [DATA_WIDTH-1:0] s1_th;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_last  <= 1'b0;
      s1_gx    <= '0;
      s1_gy    <= '0;
      s1_mode  <= MODE_MAG;
      s1_th    <= '0;
    end else if (adv) begin
      s1_valid <= s0_valid;
      s1_sof   <= s0_sof;
      s1_eol   <= s0_eol;
      s1_last  <= s0_last;
      s1_gx    <= gx_c;
      s1_gy    <= gy_c;
      s1_mode  <= s0_mode;
      s1_th    <= s0_th;
    end
  end

  logic [GW-1:0]         ax, ay;
  logic [MW-1:0]         mag;
  logic [DATA_WIDTH-1:0] mag_sat, edge_val;
  always_comb begin
    ax       = s1_gx[GW-1] ? $unsigned(-s1_gx) : $unsigned(s1_gx);
    ay       = s1_gy[GW-1] ? $unsigned(-s1_gy) : $unsigned(s1_gy);
    mag      = MW'(ax) + MW'(ay);
    mag_sat  = DATA_WIDTH'(sat_f(32'(mag), PIX_MAX));
    edge_val = (s1_mode == MODE_THRESH) ? {DATA_WIDTH{mag_sat >= s1_th}} : mag_sat;
  end

  logic m_last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_sof      <= 1'b0;
      m_eol      <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= m_valid && m_ready && m_last;
      if (adv) begin
        m_valid <= s1_valid;
        m_data  <= {3{edge_val}};
        m_sof   <= s1_sof;
        m_eol   <= s1_eol;
        m_last  <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream_core.sv
// tb/tb_sobel_stream_core.sv - randomized self-checking bench for sobel_stream_core
module tb_sobel_stream_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] cfg_width = '0, cfg_height = '0;
  logic        cfg_mode = 1'b0;
  logic [7:0]  cfg_thresh = '0;
  logic        s_valid = 1'b0, s_ready, s_sof = 1'b0;
  logic [23:0] s_data = '0;
  logic        m_valid, m_ready = 1'b0, m_sof, m_eol, frame_done;
  logic [23:0] m_data;

  always #5 clk = ~clk;

  sobel_stream_core dut (
    .clk(clk), .rst_n(rst_n), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [23:0] d; logic sof; logic [10:0] w; logic [10:0] h; logic mode; logic [7:0] th;
  } ibeat_t;
  typedef struct packed { logic [23:0] d; logic sof; logic eol; } obeat_t;

  ibeat_t      in_q[$];
  obeat_t      exp_q[$], got_q[$];
  logic [23:0] img[$];
  int checks = 0, failures = 0, exp_done = 0, done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int gray_of(input logic [23:0] px);
    return (int'(px[23:16]) + 2 * int'(px[15:8]) + int'(px[7:0])) / 4;
  endfunction

  // kind: 0 flat 0x40, 1 columns {0,0,FF,FF..}, 2 same with column 2 = 0x10, 3 random RGB
  task automatic img_fill(input int w, input int h, input int kind);
    img.delete();
    for (int i = 0; i < w * h; i++) begin
      int c = i % w;
      logic [7:0] v;
      case (kind)
        0:       v = 8'h40;
        1:       v = (c >= 2) ? 8'hFF : 8'h00;
        2:       v = (c == 2) ? 8'h10 : ((c > 2) ? 8'hFF : 8'h00);
        default: v = 8'h00;
      endcase
      img.push_back((kind == 3) ? 24'($urandom) : {v, v, v});
    end
  endtask

  task automatic add_junk(input int n);
    for (int i = 0; i < n; i++) begin
      ibeat_t b = '0;
      b.d = 24'($urandom);
      in_q.push_back(b);
    end
  endtask

  // Queues the first n beats of img as a frame and predicts its outputs directly from the image.
  task automatic add_frame(input int w, input int h, input bit mode, input int th, input int n);
    for (int i = 0; i < n; i++) begin
      ibeat_t b;
      b.d = img[i]; b.sof = (i == 0); b.w = 11'(w); b.h = 11'(h); b.mode = mode; b.th = 8'(th);
      in_q.push_back(b);
    end
    if (w < 3 || h < 3 || w > 1024) return;
    for (int r = 2; r < h; r++)
      for (int c = 2; c < w; c++)
        if (r * w + c < n) begin
          int g[3][3];
          int gx, gy, m, e;
          obeat_t ob;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              g[dr][dc] = gray_of(img[(r - 2 + dr) * w + (c - 2 + dc)]);
          gx = (g[0][2] + 2 * g[1][2] + g[2][2]) - (g[0][0] + 2 * g[1][0] + g[2][0]);
          gy = (g[2][0] + 2 * g[2][1] + g[2][2]) - (g[0][0] + 2 * g[0][1] + g[0][2]);
          m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
          if (m > 255) m = 255;
          e  = mode ? ((m >= th) ? 255 : 0) : m;
          ob.d = {3{8'(e)}}; ob.sof = (r == 2 && c == 2); ob.eol = (c == w - 1);
          exp_q.push_back(ob);
        end
    if (n >= w * h) exp_done++;
  endtask

  task automatic run(input string tag, input int rdy_pct, input int vld_pct);
    int idx = 0, idle = 0, cyc = 0;
    logic   stall = 1'b0;
    obeat_t held = '0;
    got_q.delete();
    done_cnt = 0;
    while ((idx < in_q.size() || idle < 8) && cyc < 20000) begin
      s_valid = (idx < in_q.size()) && ($urandom_range(99) < vld_pct);
      if (idx < in_q.size()) begin
        s_data = in_q[idx].d; s_sof = in_q[idx].sof;
      end else begin
        s_data = 24'($urandom); s_sof = 1'b0;
      end
      if (s_sof) begin
        cfg_width = in_q[idx].w; cfg_height = in_q[idx].h;
        cfg_mode = in_q[idx].mode; cfg_thresh = in_q[idx].th;
      end else begin
        cfg_width = 11'($urandom); cfg_height = 11'($urandom);
        cfg_mode = 1'($urandom); cfg_thresh = 8'($urandom);
      end
      m_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (stall) chk($sformatf("%s stall_hold", tag), 64'({m_valid, m_data, m_sof, m_eol}),
                     64'({1'b1, held}));
      if (frame_done) done_cnt++;
      if (m_valid && m_ready) begin
        obeat_t ob;
        ob.d = m_data; ob.sof = m_sof; ob.eol = m_eol;
        got_q.push_back(ob);
      end
      stall = m_valid && !m_ready;
      held.d = m_data; held.sof = m_sof; held.eol = m_eol;
      if (s_valid && s_ready) idx++;
      idle = (idx >= in_q.size() && !m_valid) ? idle + 1 : 0;
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    chk($sformatf("%s no_timeout", tag), 64'(cyc < 20000), 64'd1);
  endtask

  task automatic compare(input string tag);
    chk($sformatf("%s beat_count", tag), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    chk($sformatf("%s frame_done", tag), 64'(done_cnt), 64'(exp_done));
    in_q.delete();
    exp_q.delete();
    exp_done = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset m_valid", 64'(m_valid), 64'd0);
    chk("reset m_data", 64'(m_data), 64'd0);
    chk("reset m_sof_eol", 64'({m_sof, m_eol}), 64'd0);
    chk("reset frame_done", 64'(frame_done), 64'd0);
    chk("reset s_ready", 64'(s_ready), 64'd1);
    @(negedge clk);

    // T1 preceded by beats that arrive before any SOF
    add_junk(3);
    img_fill(5, 4, 0);
    add_frame(5, 4, 1'b0, 0, 20);
    run("t1", 100, 100);
    compare("t1");

    // T2 with absolute expectations for the column-step image
    img_fill(5, 4, 1);
    add_frame(5, 4, 1'b0, 0, 20);
    run("t2", 100, 100);
    if (got_q.size() == 6)
      for (int i = 0; i < 6; i++)
        chk($sformatf("t2 abs%0d", i), 64'(got_q[i].d), (i % 3 == 2) ? 64'h0 : 64'hFFFFFF);
    compare("t2");

    // T3 threshold mode, two frames back to back
    img_fill(5, 4, 1);
    add_frame(5, 4, 1'b1, 8'h80, 20);
    img_fill(5, 4, 2);
    add_frame(5, 4, 1'b1, 8'h80, 20);
    run("t3", 100, 100);
    compare("t3");

    // T4 backpressure and gaps, plus beats beyond W*H
    img_fill(5, 4, 1);
    add_frame(5, 4, 1'b0, 0, 20);
    add_junk(3);
    run("t4", 50, 60);
    compare("t4");

    // T5 mid-frame SOF at row 2 of a 6x6 frame
    img_fill(6, 6, 3);
    add_frame(6, 6, 1'b0, 0, 16);
    img_fill(5, 4, 1);
    add_frame(5, 4, 1'b0, 0, 20);
    run("t5", 70, 80);
    compare("t5");

    // random frames, invalid dimensions and the minimum 3x3 frame
    img_fill(12, 7, 3);
    add_frame(12, 7, 1'b0, 0, 84);
    img_fill(9, 5, 3);
    add_frame(9, 5, 1'b1, int'($urandom_range(255)), 45);
    img_fill(2, 4, 3);
    add_frame(2, 4, 1'b0, 0, 8);
    img_fill(1030, 3, 3);
    add_frame(1030, 3, 1'b0, 0, 3090);
    img_fill(3, 3, 3);
    add_frame(3, 3, 1'b0, 0, 9);
    run("rnd", 60, 70);
    compare("rnd");

    // T6: stream part of a frame, checking 3-cycle latency, then reset while output is stalled
    img_fill(5, 4, 1);
    for (int i = 0; i < 17; i++) begin
      s_valid    = (i < 14);
      s_data     = img[i % 20];
      s_sof      = (i == 0);
      cfg_width  = 11'd5;
      cfg_height = 11'd4;
      cfg_mode   = 1'b0;
      m_ready    = (i < 16);
      #1;
      chk($sformatf("t6 latency%0d", i), 64'(m_valid), 64'(i >= 15));
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 async m_valid", 64'(m_valid), 64'd0);
    chk("t6 async m_data", 64'(m_data), 64'd0);
    chk("t6 async flags", 64'({m_sof, m_eol, frame_done}), 64'd0);
    chk("t6 async s_ready", 64'(s_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    add_junk(2);
    img_fill(5, 4, 0);
    add_frame(5, 4, 1'b0, 0, 20);
    run("t6", 80, 90);
    compare("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
